seven_seg_scan_driver: RTL

Parametrised, time-multiplexed hex driver for a common-cathode bank of NUM_DIGITS 7-segment digits. Accepts a packed nibble word, per-digit decimal points and a per-digit blank mask through a valid/ready load port, and holds them in a shadow register. The shadow is committed to the displayed copy only at a frame boundary, so no frame ever mixes old and new digits. Scans one digit at a time at a prescaled rate. It sits between the panel's input logic and the board display pins, and generalises the single-digit combinational hex decoder.

---
 rtl/seven_seg_pkg.sv | 41 ++++
 rtl/seven_seg_scan_driver_hex_to_seg7.sv | 13 +
 rtl/seven_seg_scan_driver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment
// layout, the hex font and the leading-zero helper.
// Contents: SEG_W, SEG_* bit indices, FONT table, leading_zero_mask().
package seven_seg_pkg;

    localparam int SEG_W = 8;

    // Bit positions inside seg_o = {dp,g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // gfedcba patterns for 0..F (b and d are lower case so they differ from 8 and 0)
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bit k set when digit k (k>0) and every digit above it holds zero.
    // Digit 0 is never flagged so a value of zero still shows a single "0".
    function automatic logic [7:0] leading_zero_mask(input logic [31:0] data,
                                                     input int          num_digits);
        logic       all_zero;
        logic [7:0] mask;
        all_zero = 1'b1;
        mask     = '0;
        for (int k = 7; k >= 0; k--) begin
            if (k < num_digits) begin
                all_zero = all_zero && (data[4*k +: 4] == 4'h0);
                mask[k]  = all_zero && (k > 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seg7.sv
// Combinational nibble to gfedcba decoder using the shared font table.
// Latency: 0 cycles (pure combinational).
// Ports: nibble (4-bit hex value in), seg (7-bit gfedcba out, active-high).
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = FONT[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex driver for a common-cathode bank of 7-segment digits;
// a load is held in a shadow copy and only becomes visible at a frame boundary.
// Latency: seg/dig registered, 1 clk after index; load-to-display <= NUM_DIGITS*SCAN_DIV+1.
// Backpressure: load_ready_o low while a shadow update waits for its frame boundary.
// Ports: clk, rst_n, en_i, load_valid_i/load_ready_o/load_data_i/load_dp_i/load_blank_i,
//        seg_o {dp,g..a}, dig_o one-hot, frame_o wrap pulse.
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits (dp kept).
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [4*NUM_DIGITS-1:0] load_data_i,
    input  logic [NUM_DIGITS-1:0]   load_dp_i,
    input  logic [NUM_DIGITS-1:0]   load_blank_i,
    output logic [SEG_W-1:0]        seg_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic                    frame_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

    // Scan state
    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    logic             wrap_q;   // boundary seen last cycle; aligns frame_o with dig_o

    // Shadow and active digit sets
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [4*NUM_DIGITS-1:0] active_data;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [NUM_DIGITS-1:0]   active_blank;

    logic             tick;
    logic             boundary;
    logic             xfer;
    logic             commit;
    logic [3:0]       cur_nib;
    logic [6:0]       font_seg;
    logic [SEG_W-1:0] digit_seg;

    assign tick     = en_i && (presc == LAST_PRE);
    assign boundary = tick && (idx == LAST_IDX);
    assign xfer     = load_valid_i && !pending;
    // While the scan is stopped nothing is on screen, so the update can land at once.
    assign commit   = pending && (boundary || !en_i);

    assign load_ready_o = !pending;

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            idx    <= '0;
            wrap_q <= 1'b0;
        end else if (!en_i) begin
            presc  <= '0;
            idx    <= '0;
            wrap_q <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            wrap_q <= boundary;
            if (tick) begin
                idx <= boundary ? '0 : idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load handshake, shadow capture and frame-aligned commit.
    // xfer and commit are mutually exclusive: one needs pending low, the other high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            active_data  <= '0;
            active_dp    <= '0;
            active_blank <= '1;
        end else if (xfer) begin
            pending      <= 1'b1;
            shadow_data  <= load_data_i;
            shadow_dp    <= load_dp_i;
            shadow_blank <= load_blank_i;
        end else if (commit) begin
            pending      <= 1'b0;
            active_data  <= shadow_data;
            active_dp    <= shadow_dp;
            active_blank <= shadow_blank;
        end
    end

    // ------------------------------------------------------------------
    // Segment pattern for the digit currently selected by idx
    // ------------------------------------------------------------------
    assign cur_nib = active_data[idx*4 +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nib),
        .seg    (font_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] lz_mask;
    assign lz_mask = leading_zero_mask(32'(active_data), NUM_DIGITS);
`endif

    always_comb begin
        digit_seg              = '0;
        digit_seg[SEG_DP]      = active_dp[idx];
        digit_seg[SEG_G:SEG_A] = font_seg;
`ifdef LEADING_ZERO_BLANK_EN
        // Suppressed zero: glyph dark, decimal point still shown
        if (lz_mask[idx]) begin
            digit_seg[SEG_G:SEG_A] = '0;
        end
`endif
        // Explicit blank darkens the whole digit including dp
        if (active_blank[idx]) begin
            digit_seg = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= '0;
            dig_o   <= '0;
            frame_o <= 1'b0;
        end else if (!en_i) begin
            seg_o   <= '0;
            dig_o   <= '0;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= digit_seg;
            dig_o   <= NUM_DIGITS'(1) << idx;
            frame_o <= wrap_q;
        end
    end

endmodule
